// File: rtl/vec_add_pipe.sv
// Two-stage pipelined SIMD add/subtract lane, carry chain cut at SEW element boundaries.
// Optional signed saturation is enabled by defining VEC_ADD_SAT_EN (adds port in_sat).
module vec_add_pipe #(
    parameter  int DATA_W  = 32,
    parameter  int CHUNK_W = 8,
    localparam int NCH     = DATA_W / CHUNK_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sub,
    input  logic [1:0]        in_sew,
`ifdef VEC_ADD_SAT_EN
    input  logic              in_sat,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [NCH-1:0]    out_cout
);

    localparam int unsigned HALF = NCH / 2;
    localparam int unsigned HW   = DATA_W / 2;

    // Chunks per element; the reserved encoding behaves as 8-bit elements.
    function automatic int unsigned f_epc(input logic [1:0] sew);
        case (sew)
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    logic              r_init;
    logic              r_s1_valid;
    logic [HW-1:0]     r_s1_lo_sum;
    logic [HALF-1:0]   r_s1_lo_cout;
    logic [HW-1:0]     r_s1_a_hi;
    logic [HW-1:0]     r_s1_b_hi;
    logic              r_s1_sub;
    logic [1:0]        r_s1_sew;
    logic              r_s1_carry;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_sum;
    logic [NCH-1:0]    r_s2_cout;

    logic [DATA_W-1:0] w_b_prep;
    logic [HW-1:0]     w_lo_sum;
    logic [HALF-1:0]   w_lo_cout;
    logic              w_lo_carry;
    logic [HW-1:0]     w_hi_sum;
    logic [HALF-1:0]   w_hi_cout;
    logic [DATA_W-1:0] w_sum;
    logic [NCH-1:0]    w_cout;
    logic [DATA_W-1:0] w_res;
    logic              w_s2_load;
    logic              w_in_xfer;

`ifdef VEC_ADD_SAT_EN
    logic              r_s1_sat;
    logic [HALF-1:0]   r_s1_lo_ovf;
    logic [HALF-1:0]   w_lo_ovf;
    logic [HALF-1:0]   w_hi_ovf;
    logic [NCH-1:0]    w_ovf;
`endif

    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = r_init & (~r_s1_valid | w_s2_load);
    assign w_in_xfer = in_valid & in_ready;

    // Lower half of the chunk chain, evaluated on the incoming operands.
    always_comb begin : s1_add
        logic              v_c;
        logic [CHUNK_W:0]  v_t;
        int unsigned       v_epc;
        w_b_prep  = in_sub ? ~in_b : in_b;
        v_epc     = f_epc(in_sew);
        v_c       = in_sub;
        v_t       = '0;
        w_lo_sum  = '0;
        w_lo_cout = '0;
`ifdef VEC_ADD_SAT_EN
        w_lo_ovf  = '0;
`endif
        for (int unsigned k = 0; k < HALF; k++) begin
            if ((k % v_epc) == 0) v_c = in_sub;
            v_t = {1'b0, in_a[k*CHUNK_W +: CHUNK_W]} + {1'b0, w_b_prep[k*CHUNK_W +: CHUNK_W]}
                + {{CHUNK_W{1'b0}}, v_c};
            w_lo_sum[k*CHUNK_W +: CHUNK_W] = v_t[CHUNK_W-1:0];
            w_lo_cout[k] = (((k + 1) % v_epc) == 0) ? v_t[CHUNK_W] : 1'b0;
`ifdef VEC_ADD_SAT_EN
            w_lo_ovf[k] = v_t[CHUNK_W] ^ in_a[k*CHUNK_W + CHUNK_W-1]
                        ^ w_b_prep[k*CHUNK_W + CHUNK_W-1] ^ v_t[CHUNK_W-1];
`endif
            v_c = v_t[CHUNK_W];
        end
        w_lo_carry = v_c;
    end

    // Upper half, continuing from the registered carry of the lower half.
    always_comb begin : s2_add
        logic              v_c;
        logic [CHUNK_W:0]  v_t;
        int unsigned       v_epc;
        int unsigned       v_j;
        v_epc     = f_epc(r_s1_sew);
        v_c       = r_s1_carry;
        v_t       = '0;
        v_j       = 0;
        w_hi_sum  = '0;
        w_hi_cout = '0;
`ifdef VEC_ADD_SAT_EN
        w_hi_ovf  = '0;
`endif
        for (int unsigned k = HALF; k < NCH; k++) begin
            v_j = k - HALF;
            if ((k % v_epc) == 0) v_c = r_s1_sub;
            v_t = {1'b0, r_s1_a_hi[v_j*CHUNK_W +: CHUNK_W]} + {1'b0, r_s1_b_hi[v_j*CHUNK_W +: CHUNK_W]}
                + {{CHUNK_W{1'b0}}, v_c};
            w_hi_sum[v_j*CHUNK_W +: CHUNK_W] = v_t[CHUNK_W-1:0];
            w_hi_cout[v_j] = (((k + 1) % v_epc) == 0) ? v_t[CHUNK_W] : 1'b0;
`ifdef VEC_ADD_SAT_EN
            w_hi_ovf[v_j] = v_t[CHUNK_W] ^ r_s1_a_hi[v_j*CHUNK_W + CHUNK_W-1]
                          ^ r_s1_b_hi[v_j*CHUNK_W + CHUNK_W-1] ^ v_t[CHUNK_W-1];
`endif
            v_c = v_t[CHUNK_W];
        end
    end

    assign w_sum  = {w_hi_sum, r_s1_lo_sum};
    assign w_cout = {w_hi_cout, r_s1_lo_cout};

`ifdef VEC_ADD_SAT_EN
    // Overflow is judged at each element's top chunk; every chunk of that element is replaced.
    always_comb begin : s2_sat
        int unsigned v_epc;
        int unsigned v_top;
        logic        v_msb;
        w_ovf = {w_hi_ovf, r_s1_lo_ovf};
        w_res = w_sum;
        v_epc = f_epc(r_s1_sew);
        v_top = 0;
        v_msb = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            v_top = k | (v_epc - 1);
            v_msb = w_sum[v_top*CHUNK_W + CHUNK_W-1];
            if (r_s1_sat && w_ovf[v_top]) begin
                if (k == v_top)
                    w_res[k*CHUNK_W +: CHUNK_W] = v_msb ? {1'b0, {(CHUNK_W-1){1'b1}}}
                                                        : {1'b1, {(CHUNK_W-1){1'b0}}};
                else
                    w_res[k*CHUNK_W +: CHUNK_W] = {CHUNK_W{v_msb}};
            end
        end
    end
`else
    assign w_res = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init       <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_lo_sum  <= '0;
            r_s1_lo_cout <= '0;
            r_s1_a_hi    <= '0;
            r_s1_b_hi    <= '0;
            r_s1_sub     <= 1'b0;
            r_s1_sew     <= '0;
            r_s1_carry   <= 1'b0;
`ifdef VEC_ADD_SAT_EN
            r_s1_sat     <= 1'b0;
            r_s1_lo_ovf  <= '0;
`endif
            r_s2_valid   <= 1'b0;
            r_s2_sum     <= '0;
            r_s2_cout    <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_in_xfer) begin
                r_s1_valid   <= 1'b1;
                r_s1_lo_sum  <= w_lo_sum;
                r_s1_lo_cout <= w_lo_cout;
                r_s1_a_hi    <= in_a[DATA_W-1:HW];
                r_s1_b_hi    <= w_b_prep[DATA_W-1:HW];
                r_s1_sub     <= in_sub;
                r_s1_sew     <= in_sew;
                r_s1_carry   <= w_lo_carry;
`ifdef VEC_ADD_SAT_EN
                r_s1_sat     <= in_sat;
                r_s1_lo_ovf  <= w_lo_ovf;
`endif
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_sum   <= w_res;
                r_s2_cout  <= w_cout;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sum   = r_s2_sum;
    assign out_cout  = r_s2_cout;

endmodule

// File: tb/tb_vec_add_pipe.sv
// Self-checking bench for vec_add_pipe: per-element arithmetic model plus directed literal checks.
module tb_vec_add_pipe;

    localparam int DATA_W = 32;
    localparam int NCH    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              in_sub = 1'b0;
    logic [1:0]        in_sew = '0;
`ifdef VEC_ADD_SAT_EN
    logic              in_sat = 1'b0;
`endif
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_sum;
    logic [NCH-1:0]    out_cout;

    typedef struct packed {
        logic [NCH-1:0]    cout;
        logic [DATA_W-1:0] sum;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [1:0]  sew;
    } vec_t;

    res_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   n_flush = 0;

    vec_add_pipe #(.DATA_W(DATA_W), .CHUNK_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .in_sew   (in_sew),
`ifdef VEC_ADD_SAT_EN
        .in_sat   (in_sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
    );

    always #5 clk = ~clk;

    // Element-wise arithmetic on plain integers; cout lands on the element's top byte.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                   input logic [1:0] sew, input logic sat);
        res_t   r;
        longint ew, md, ae, be, rv, sa, sb, sr;
        logic   c;
        r  = '0;
        ew = (sew == 2'b01) ? 16 : (sew == 2'b10) ? 32 : 8;
        md = longint'(1) << ew;
        for (int e = 0; e < DATA_W / ew; e++) begin
            ae = (longint'(a) >> (e * ew)) % md;
            be = (longint'(b) >> (e * ew)) % md;
            if (sub) begin
                rv = ae - be;
                c  = (ae >= be);
            end else begin
                rv = ae + be;
                c  = (rv >= md);
            end
            rv = ((rv % md) + md) % md;
            if (sat) begin
                sa = (ae >= md / 2) ? ae - md : ae;
                sb = (be >= md / 2) ? be - md : be;
                sr = sub ? sa - sb : sa + sb;
                if (sr > md / 2 - 1) rv = md / 2 - 1;
                else if (sr < -(md / 2)) rv = md / 2;
            end
            r.sum = r.sum | (DATA_W'(rv) << (e * ew));
            r.cout[e * ew / 8 + ew / 8 - 1] = c;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [1:0] sew);
        int waited;
        waited = 0;
        in_a = a; in_b = b; in_sub = sub; in_sew = sew; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // One beat with out_ready=1, checking latency and literal result.
    task automatic run1(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [1:0] sew,
                        input logic [31:0] exp_sum, input logic [3:0] exp_cout);
        send(a, b, sub, sew);
        @(negedge clk);
        chk({name, "_valid_early"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_sum"}, {32'd0, out_sum}, {32'd0, exp_sum});
        chk({name, "_cout"}, {60'd0, out_cout}, {60'd0, exp_cout});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1 chk("drain", 64'(q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
`ifdef VEC_ADD_SAT_EN
                q.push_back(model(in_a, in_b, in_sub, in_sew, in_sat));
`else
                q.push_back(model(in_a, in_b, in_sub, in_sew, 1'b0));
`endif
                n_in++;
            end
        end
    end

    always @(negedge rst_n) begin
        n_flush += q.size();
        q.delete();
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("out_unexpected", {63'd0, out_valid}, 64'd0);
            end else begin
                chk("sb_sum", {32'd0, out_sum}, {32'd0, q[0].sum});
                chk("sb_cout", {60'd0, out_cout}, {60'd0, q[0].cout});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 2'b00};
        tbl[1] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 2'b01};
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 2'b10};
        tbl[3] = '{32'h0001_0000, 32'h0000_0001, 1'b1, 2'b10};
        tbl[4] = '{32'hFF00_FF00, 32'h0101_0101, 1'b0, 2'b11};
        tbl[5] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 2'b00};

        // Model pinned against hand-computed results.
        chk("model_sew32", 64'(model(32'hFFFF_FFFF, 32'h1, 1'b0, 2'b10, 1'b0)), {28'd0, 4'b1000, 32'h0});
        chk("model_sew8", 64'(model(32'h01FF_80FF, 32'h0101_8001, 1'b0, 2'b00, 1'b0)), {28'd0, 4'b0111, 32'h0200_0000});
        chk("model_sew16", 64'(model(32'h0005_0000, 32'h0001_0001, 1'b1, 2'b01, 1'b0)), {28'd0, 4'b1000, 32'h0004_FFFF});
        chk("model_sat_neg", 64'(model(32'h80, 32'h01, 1'b1, 2'b00, 1'b1)), {28'd0, 4'b1111, 32'h80});

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_out_cout", {60'd0, out_cout}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        run1("t_sew32_add", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b10, 32'h0000_0000, 4'b1000);
        run1("t_sew8_add", 32'h01FF_80FF, 32'h0101_8001, 1'b0, 2'b00, 32'h0200_0000, 4'b0111);
        run1("t_sew16_sub", 32'h0005_0000, 32'h0001_0001, 1'b1, 2'b01, 32'h0004_FFFF, 4'b1000);

        for (int i = 0; i < 6; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sew);
        drain();

        // Backpressure: hold out_ready low for three cycles while four beats are offered.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(32'h1000_0000 * (i + 1) + 32'h0101_0101, 32'h0000_00F0 + i, 1'b0, 2'b00);
            end
            begin
                repeat (2) @(posedge clk);
                #1 chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                chk("bp_held_valid", {63'd0, out_valid}, 64'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_no_gap", {63'd0, out_valid}, 64'd1);
                end
            end
        join
        drain();

        // Reset while both stages hold beats.
        out_ready = 1'b0;
        send(32'hAAAA_5555, 32'h1111_1111, 1'b0, 2'b10);
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 2'b00);
        @(negedge clk);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_after_rst", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

`ifdef VEC_ADD_SAT_EN
        in_sat = 1'b1;
        run1("sat_pos", 32'h0000_007F, 32'h0000_0001, 1'b0, 2'b00, 32'h0000_007F, 4'b0000);
        run1("sat_neg", 32'h0000_0080, 32'h0000_0001, 1'b1, 2'b00, 32'h0000_0080, 4'b1111);
        in_sat = 1'b0;
        run1("wrap_pos", 32'h0000_007F, 32'h0000_0001, 1'b0, 2'b00, 32'h0000_0080, 4'b0000);
        run1("wrap_neg", 32'h0000_0080, 32'h0000_0001, 1'b1, 2'b00, 32'h0000_007F, 4'b1111);
`endif

        drain();
        chk("beat_count", 64'(n_out), 64'(n_in - n_flush));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
